ballot_gate: RTL and testbench

Voter-session front end that sits between the four raw candidate push-buttons plus the presiding officer's arm button, and the button inputs of the voting machine top level. It synchronises and debounces every switch and enforces one vote per armed session. A single accepted press is forwarded as a clean fixed-length one-hot pulse on `btn_out[3:0]`; multi-presses, unarmed presses and timed-out sessions are rejected.

---
 rtl/ballot_gate.sv | 179 +++++++++++++++++
 tb/tb_ballot_gate.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_gate.sv
// Voter-session gate: conditions the arm and candidate buttons, then forwards
// exactly one debounced candidate press per armed session as a fixed-length one-hot pulse.

module ballot_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ballot_gate #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int PULSE_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       arm_raw,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_out,
    output logic       booth_ready,
    output logic       vote_done,
    output logic       reject,
    output logic [2:0] state
);
    localparam int NUM_LANES = 5;
    localparam int TW = $clog2(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 2);
    localparam int PW = $clog2(PULSE_CYCLES > 1 ? PULSE_CYCLES : 2);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARMED    = 3'd1;
    localparam logic [2:0] EMIT     = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] REJ_WAIT = 3'd4;

    logic [NUM_LANES-1:0] raw_all, db, db_q, rise;

    assign raw_all = {arm_raw, btn_raw};

    // Lane 4 is the officer arm button, lanes 3..0 the candidates.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        ballot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_all[i]),
            .level (db[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) db_q <= '0;
        else      db_q <= db;
    end

    assign rise = db & ~db_q;

    logic [3:0]    cand_db;
    logic          cand_one;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [2:0]    state_nxt;
    logic [3:0]    btn_nxt;
    logic          rej_nxt, done_nxt;

    assign cand_db  = db[3:0];
    assign cand_one = (cand_db != 4'd0) && ((cand_db & (cand_db - 4'd1)) == 4'd0);

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        pcnt_nxt  = pcnt;
        btn_nxt   = btn_out;
        rej_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rise[4] && !mode) begin
                    state_nxt = ARMED;
                    tcnt_nxt  = '0;
                end
            end
            ARMED: begin
                if (mode) begin
                    state_nxt = IDLE;
                end else if (rise[3:0] != 4'd0) begin
                    if (cand_one) begin
                        btn_nxt   = cand_db;
                        pcnt_nxt  = '0;
                        state_nxt = EMIT;
                    end else begin
                        rej_nxt   = 1'b1;
                        state_nxt = REJ_WAIT;
                    end
                end else if (tcnt == T_LAST) begin
                    rej_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            // mode is deliberately not looked at here so an accepted vote completes.
            EMIT: begin
                if (pcnt == P_LAST) begin
                    btn_nxt   = 4'd0;
                    done_nxt  = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            HOLD: begin
                if (cand_db == 4'd0) state_nxt = IDLE;
            end
            REJ_WAIT: begin
                if (mode) begin
                    state_nxt = IDLE;
                end else if (cand_db == 4'd0) begin
                    state_nxt = ARMED;
                    tcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                btn_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            pcnt        <= '0;
            btn_out     <= 4'd0;
            booth_ready <= 1'b0;
            vote_done   <= 1'b0;
            reject      <= 1'b0;
        end else begin
            state       <= state_nxt;
            tcnt        <= tcnt_nxt;
            pcnt        <= pcnt_nxt;
            btn_out     <= btn_nxt;
            booth_ready <= (state_nxt == ARMED);
            vote_done   <= done_nxt;
            reject      <= rej_nxt;
        end
    end
endmodule

// File: tb/tb_ballot_gate.sv
// Bench for ballot_gate: directed test-plan scenarios plus random button traffic,
// every cycle compared against a run-length / session-age reference model.

module tb_ballot_gate;
    localparam int D = 4;
    localparam int T = 50;
    localparam int P = 3;

    logic       clk, rst, mode, arm_raw;
    logic [3:0] btn_raw;
    logic [3:0] btn_out;
    logic       booth_ready, vote_done, reject;
    logic [2:0] state;

    ballot_gate #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .PULSE_CYCLES(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .arm_raw     (arm_raw),
        .btn_raw     (btn_raw),
        .btn_out     (btn_out),
        .booth_ready (booth_ready),
        .vote_done   (vote_done),
        .reject      (reject),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level flips after D consecutive cycles of disagreement
    // with the 2-cycle-delayed raw input; the session is tracked by age and pulse budget.
    bit [4:0]   m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvlq = '0;
    int         run [5] = '{0, 0, 0, 0, 0};
    int         m_state = 0, m_age = 0, m_left = 0;
    bit [3:0]   m_vote = '0;
    bit         e_done = 0, e_rej = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlq = '0;
            for (int i = 0; i < 5; i++) run[i] = 0;
            m_state = 0; m_age = 0; m_left = 0; m_vote = '0;
            e_done = 0; e_rej = 0;
        end else begin
            bit [4:0] rise;
            bit [3:0] cand;
            rise   = m_lvl & ~m_lvlq;
            cand   = m_lvl[3:0];
            e_done = 0;
            e_rej  = 0;
            case (m_state)
                0: if (rise[4] && !mode) begin m_state = 1; m_age = 0; end
                1: begin
                    if (mode) m_state = 0;
                    else if (rise[3:0] != 0) begin
                        if ($countones(cand) == 1) begin
                            m_vote = cand; m_left = P; m_state = 2;
                        end else begin
                            e_rej = 1; m_state = 4;
                        end
                    end else begin
                        m_age++;
                        if (m_age == T) begin e_rej = 1; m_state = 0; end
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin e_done = 1; m_state = 3; end
                end
                3: if (cand == 0) m_state = 0;
                4: begin
                    if (mode) m_state = 0;
                    else if (cand == 0) begin m_state = 1; m_age = 0; end
                end
                default: m_state = 0;
            endcase
            m_lvlq = m_lvl;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] == m_lvl[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == D) begin m_lvl[i] = m_s2[i]; run[i] = 0; end
                end
            end
            m_s2 = m_s1;
            m_s1 = {arm_raw, btn_raw};
        end
    end

    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [9:0] exp_v;
            exp_v = {3'(m_state), (m_state == 2) ? m_vote : 4'd0, 1'(m_state == 1), e_done, e_rej};
            chk("cycle_model", {22'd0, state, btn_out, booth_ready, vote_done, reject}, {22'd0, exp_v});
        end
    end

    // Pulse / event monitor used by the directed scenarios.
    int         pulses = 0, dones = 0, rejs = 0, cur_w = 0, last_w = 0;
    logic [3:0] last_pulse = '0, prev_btn = '0;
    always @(negedge clk) begin
        if (btn_out != 0 && prev_btn == 0) begin
            pulses++; last_pulse = btn_out; cur_w = 0;
        end
        if (btn_out != 0) cur_w++;
        else if (prev_btn != 0) last_w = cur_w;
        if (vote_done) dones++;
        if (reject) rejs++;
        prev_btn = btn_out;
    end

    task automatic do_arm();
        arm_raw = 1'b1; tick(8);
        arm_raw = 1'b0; tick(8);
    endtask

    task automatic wait_btn(output int e);
        e = 0;
        do begin
            @(posedge clk); #1; e++;
        end while (btn_out == 0 && e < 20);
    endtask

    int p0, d0, r0, e;

    initial begin
        rst = 1'b0; mode = 1'b0; arm_raw = 1'b0; btn_raw = 4'd0;
        tick(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", {28'd0, btn_out}, 32'd0);
        chk("rst_flags", {29'd0, booth_ready, vote_done, reject}, 32'd0);
        rst = 1'b1;
        cmp_on = 1;
        tick(2);

        // Clean vote
        do_arm();
        chk("armed", 32'(booth_ready), 32'd1);
        p0 = pulses; d0 = dones; r0 = rejs;
        btn_raw = 4'b0010;
        wait_btn(e);
        chk("vote_latency", 32'(e), 32'd7);
        chk("vote_ready_low", 32'(booth_ready), 32'd0);
        tick(10);
        chk("vote_pulses", 32'(pulses - p0), 32'd1);
        chk("vote_value", 32'(last_pulse), 32'b0010);
        chk("vote_width", 32'(last_w), 32'(P));
        chk("vote_done_cnt", 32'(dones - d0), 32'd1);
        btn_raw = 4'd0; tick(10);
        chk("vote_idle", 32'(state), 32'd0);

        // Bounce
        do_arm();
        p0 = pulses; r0 = rejs;
        for (int k = 0; k < 10; k++) begin
            btn_raw[0] = ~btn_raw[0]; tick(2);
        end
        btn_raw = 4'b0001; tick(12);
        chk("bounce_pulses", 32'(pulses - p0), 32'd1);
        chk("bounce_value", 32'(last_pulse), 32'b0001);
        chk("bounce_no_rej", 32'(rejs - r0), 32'd0);
        btn_raw = 4'd0; tick(10);

        // Multi-press, then a clean retry in the same session
        do_arm();
        p0 = pulses; r0 = rejs;
        btn_raw = 4'b0101; tick(12);
        chk("multi_rej", 32'(rejs - r0), 32'd1);
        chk("multi_no_pulse", 32'(pulses - p0), 32'd0);
        chk("multi_state", 32'(state), 32'd4);
        btn_raw = 4'd0; tick(10);
        chk("multi_rearmed", 32'(state), 32'd1);
        btn_raw = 4'b0100; tick(12);
        chk("retry_pulses", 32'(pulses - p0), 32'd1);
        chk("retry_value", 32'(last_pulse), 32'b0100);
        btn_raw = 4'd0; tick(10);

        // Timeout
        do_arm();
        p0 = pulses; r0 = rejs;
        tick(60);
        chk("tmo_rej", 32'(rejs - r0), 32'd1);
        chk("tmo_state", 32'(state), 32'd0);
        btn_raw = 4'b1000; tick(12);
        chk("tmo_no_pulse", 32'(pulses - p0), 32'd0);
        btn_raw = 4'd0; tick(10);

        // Press without arming, then mode abort
        p0 = pulses; r0 = rejs;
        btn_raw = 4'b0010; tick(12);
        chk("unarmed_no_pulse", 32'(pulses - p0), 32'd0);
        btn_raw = 4'd0; tick(10);
        do_arm();
        mode = 1'b1; tick(2);
        chk("mode_state", 32'(state), 32'd0);
        chk("mode_ready", 32'(booth_ready), 32'd0);
        chk("mode_no_rej", 32'(rejs - r0), 32'd0);
        mode = 1'b0; tick(2);

        // Reset during the second btn_out cycle
        do_arm();
        btn_raw = 4'b0001;
        wait_btn(e);
        chk("rstmid_started", 32'(btn_out), 32'b0001);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("rstmid_btn", 32'(btn_out), 32'd0);
        chk("rstmid_state", 32'(state), 32'd0);
        tick(3);
        rst = 1'b1;
        p0 = pulses;
        tick(15);
        chk("rstmid_no_resume", 32'(pulses - p0), 32'd0);
        btn_raw = 4'd0; tick(10);

        // Random traffic against the model
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_arm();
                3, 4: begin
                    btn_raw = 4'(1 << $urandom_range(0, 3));
                    tick($urandom_range(2, 14));
                end
                5, 6: begin
                    btn_raw = 4'($urandom_range(0, 15));
                    tick($urandom_range(2, 14));
                end
                7: begin btn_raw = 4'd0; tick(8); end
                8: begin mode = 1'b1; tick($urandom_range(1, 4)); mode = 1'b0; end
                default: tick($urandom_range(1, 30));
            endcase
        end
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end
endmodule
